// File: rtl/morra_cinese_param_if.sv
// Handshake bundle between the player-input front end and the match controller.
// The front end drives the moves and strobes; the controller returns the round
// result, the match result and the number of valid rounds played.
interface morra_cinese_param_if #(
    parameter int MOVE_W = 2
);
    localparam int CNT_W = 2 * MOVE_W + 1;

    logic              INIZIA;
    logic              VALIDO;
    logic [MOVE_W-1:0] PRIMO;
    logic [MOVE_W-1:0] SECONDO;
    logic [1:0]        MANCHE;
    logic [1:0]        PARTITA;
    logic [CNT_W-1:0]  NMANCHE;

    modport master (
        output INIZIA, VALIDO, PRIMO, SECONDO,
        input  MANCHE, PARTITA, NMANCHE
    );

    modport slave (
        input  INIZIA, VALIDO, PRIMO, SECONDO,
        output MANCHE, PARTITA, NMANCHE
    );
endinterface

// File: rtl/morra_cinese_param.sv
// Parametrised rock-paper-scissors match controller.
// Moves are sampled on VALIDO while a match is in progress; each valid round
// updates the round counter and the signed lead, and the match result is
// decided on the same edge as the deciding round. Once decided the match is
// frozen until INIZIA reloads the round limit and restarts it.
// A winner may not repeat its winning move in the very next round: that round
// is discarded. A tie, or another win, replaces or clears that restriction.
module morra_cinese_param #(
    parameter int MOVE_W     = 2,
    parameter int N_MOVES    = 3,
    parameter int MIN_MANCHE = 4,
    parameter int LEAD       = 2,
    parameter int EXTRA      = 4
) (
    input logic                 clk,
    input logic                 rst,
    morra_cinese_param_if.slave bus
);
    localparam int CNT_W = 2 * MOVE_W + 1;

    localparam logic [MOVE_W-1:0]      N_CODE    = MOVE_W'(N_MOVES);
    localparam logic [MOVE_W:0]        N_WIDE    = (MOVE_W + 1)'(N_MOVES);
    localparam logic [MOVE_W:0]        HALF      = (MOVE_W + 1)'((N_MOVES - 1) / 2);
    localparam logic [CNT_W-1:0]       MIN_CNT   = CNT_W'(MIN_MANCHE);
    localparam logic [CNT_W-1:0]       EXTRA_CNT = CNT_W'(EXTRA);
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic signed [CNT_W:0]  LEAD_ONE  = (CNT_W + 1)'(1);
    localparam logic signed [CNT_W:0]  LEAD_POS  = (CNT_W + 1)'(LEAD);
    localparam logic signed [CNT_W:0]  LEAD_NEG  = -LEAD_POS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]      count, count_d, count_upd;
    logic [CNT_W-1:0]      limit, limit_d;
    logic signed [CNT_W:0] lead, lead_d, lead_upd;
    logic                  lock_v, lock_v_d;
    logic                  lock_p2, lock_p2_d;
    logic [MOVE_W-1:0]     lock_mv, lock_mv_d;
    logic [1:0]            manche, manche_d;
    logic [1:0]            partita, partita_d;

    logic                  evaluate;
    logic                  moves_ok;
    logic                  lock_hit;
    logic [MOVE_W:0]       diff;
    logic [MOVE_W:0]       diff_mod;
    logic [1:0]            round_res;
    logic [1:0]            decision;

    // Classify the sampled moves and work out the round and match outcome.
    always_comb begin
        evaluate  = (state == PLAY) && bus.VALIDO && !bus.INIZIA;
        moves_ok  = (bus.PRIMO != '0) && (bus.PRIMO <= N_CODE) &&
                    (bus.SECONDO != '0) && (bus.SECONDO <= N_CODE);
        lock_hit  = lock_v && (lock_p2 ? (bus.SECONDO == lock_mv)
                                       : (bus.PRIMO == lock_mv));
        diff      = {1'b0, bus.PRIMO} + N_WIDE - {1'b0, bus.SECONDO};
        diff_mod  = (diff >= N_WIDE) ? (diff - N_WIDE) : diff;
        round_res = 2'b00;
        if (evaluate && moves_ok && !lock_hit) begin
            if (bus.PRIMO == bus.SECONDO) begin
                round_res = 2'b11;
            end else if ((diff_mod != '0) && (diff_mod <= HALF)) begin
                round_res = 2'b01;
            end else begin
                round_res = 2'b10;
            end
        end
        count_upd = count + CNT_ONE;
        lead_upd  = lead;
        if (round_res == 2'b01) begin
            lead_upd = lead + LEAD_ONE;
        end else if (round_res == 2'b10) begin
            lead_upd = lead - LEAD_ONE;
        end
        decision = 2'b00;
        if ((count_upd >= MIN_CNT) && (lead_upd >= LEAD_POS)) begin
            decision = 2'b01;
        end else if ((count_upd >= MIN_CNT) && (lead_upd <= LEAD_NEG)) begin
            decision = 2'b10;
        end else if (count_upd == limit) begin
            decision = 2'b11;
        end
    end

    // Match state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Restart from any state on INIZIA; leave PLAY once a round decides the match.
    always_comb begin
        state_next = state;
        if (bus.INIZIA) begin
            state_next = PLAY;
        end else if ((state == PLAY) && (round_res != 2'b00) && (decision != 2'b00)) begin
            state_next = DONE;
        end
    end

    // Next values of the counters, lock and result registers.
    always_comb begin
        count_d   = count;
        limit_d   = limit;
        lead_d    = lead;
        lock_v_d  = lock_v;
        lock_p2_d = lock_p2;
        lock_mv_d = lock_mv;
        manche_d  = 2'b00;
        partita_d = partita;
        if (bus.INIZIA) begin
            limit_d   = {1'b0, bus.PRIMO, bus.SECONDO} + EXTRA_CNT;
            count_d   = '0;
            lead_d    = '0;
            lock_v_d  = 1'b0;
            partita_d = 2'b00;
        end else if (round_res != 2'b00) begin
            manche_d  = round_res;
            count_d   = count_upd;
            lead_d    = lead_upd;
            partita_d = decision;
            if (round_res == 2'b11) begin
                lock_v_d = 1'b0;
            end else begin
                lock_v_d  = 1'b1;
                lock_p2_d = (round_res == 2'b10);
                lock_mv_d = (round_res == 2'b10) ? bus.SECONDO : bus.PRIMO;
            end
        end
    end

    // Datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            limit   <= '0;
            lead    <= '0;
            lock_v  <= 1'b0;
            lock_p2 <= 1'b0;
            lock_mv <= '0;
            manche  <= 2'b00;
            partita <= 2'b00;
        end else begin
            count   <= count_d;
            limit   <= limit_d;
            lead    <= lead_d;
            lock_v  <= lock_v_d;
            lock_p2 <= lock_p2_d;
            lock_mv <= lock_mv_d;
            manche  <= manche_d;
            partita <= partita_d;
        end
    end

    assign bus.MANCHE  = manche;
    assign bus.PARTITA = partita;
    assign bus.NMANCHE = count;

endmodule
